formato_12_ctrl: RTL and testbench
==================================

# formato_12_ctrl

Sequencing controller for the 12-hour counter of the clock datapath. It arbitrates hour-advance requests between the timekeeping carry (`tick_hr`) and the user set buttons, and drives the counter's `en12`/`up12`/`down12` strobes. It keeps the displayed hour inside 1..12 by issuing corrective pulse bursts around the counter's native wrap points, and it tracks the AM/PM flag.

## Interface
- `REPEAT_DLY`, default 25_000_000: cycles a button must be held before auto-repeat starts (macro build only).
- `REPEAT_PER`, default 5_000_000: cycles between auto-repeat requests (macro build only).
- `clk12` in 1: clock.
- `reset12` in 1: reset, asynchronous, active-high.
- `set_mode` in 1: 1 = user set mode, 0 = run mode.
- `tick_hr` in 1: one-cycle hour carry from the minute counter.
- `btn_up` in 1: synchronized, debounced level.
- `btn_down` in 1: synchronized, debounced level.
- `q12_in` in 4: current hour counter value.
- `en12` out 1: counter enable strobe, registered.
- `up12` out 1: count-up strobe, registered.
- `down12` out 1: count-down strobe, registered.
- `pm` out 1: 0 = AM, 1 = PM.
- `busy` out 1: a request is in progress.

## Operation
- Counter semantics driven by this block:
  - up: 12→0, otherwise +1.
  - down: −1 mod 16.
  - Legal hour range: 1..12.
- Every strobe cycle asserts `en12=1` with exactly one of `up12`/`down12`. All three outputs are 0 otherwise.
- FSM states: INIT, IDLE, ISSUE, FIX, SETTLE.
  - **INIT** (entered on reset): issue one up (0→1), then SETTLE.
  - **IDLE**: accept one request per cycle, then go to ISSUE.
  - **ISSUE**: one strobe.
  - **FIX**: corrective burst of consecutive up strobes, tracked by an internal 4-bit count.
  - **SETTLE**: one idle cycle so `q12_in` reflects the last strobe; then IDLE.
- Request sources:
  - Run mode: `tick_hr` is an up request. Buttons are ignored.
  - Set mode: rising edge of `btn_up` is an up request; rising edge of `btn_down` is a down request.
  - Set mode: `tick_hr` is latched into a 1-deep pending flag and served in the first IDLE cycle after `set_mode` falls. Further ticks while the flag is set are dropped.
  - Run mode while busy: `tick_hr` sets the pending flag; it is served at the next IDLE.
  - Button edges while busy are discarded.
  - `btn_up` and `btn_down` edges in the same cycle: both discarded.
- Decisions use `q12_in` sampled in the IDLE accept cycle:
  - Up with q=12: ISSUE up, then FIX 1 more up (12→0→1).
  - Down with q=1: ISSUE nothing; FIX 11 ups (1→12).
  - Otherwise: single strobe.
  - Any `q12_in` outside 1..12 seen in IDLE (0 or 13..15): go to INIT-style repair, issuing ups until q=1, re-checking after each SETTLE.
- AM/PM:
  - `pm` toggles on accepted up with q=11.
  - `pm` toggles on accepted down with q=12.
  - Corrective bursts never toggle `pm`.

## Timing
- Reset values: `en12=0`, `up12=0`, `down12=0`, `pm=0`, `busy=1`, state INIT, pending flag 0, edge registers 0.
- Reset mid-burst: outputs drop to 0 immediately (async). The counter is reset by the same net, so INIT restarts from q=0.
- Request accepted in IDLE at cycle n. First strobe is high in cycle n+1. The counter updates at the end of n+1.
- Total busy duration:
  - Plain request: 3 cycles (accept, ISSUE, SETTLE).
  - Up at 12: 4 cycles.
  - Down at 1: 13 cycles (accept, 11 FIX, SETTLE).
- `busy` is high from the cycle after acceptance through SETTLE inclusive, and during INIT.
- `pm` updates in the same cycle as the first strobe.
- Minimum spacing between independent requests: 3 cycles.

## Configuration
- Macro: `FORMATO_12_AUTOREPEAT_EN`.
- Defined:
  - In set mode, a button held continuously for `REPEAT_DLY` cycles generates a further request, then one every `REPEAT_PER` cycles while held.
  - Repeat requests falling while busy are discarded.
  - Releasing the button, or both buttons high, clears the hold counter.
- Undefined: edge-only requests. Parameters are unused; no hold counter logic is present.

## Test plan
- Release reset with counter at 0 → single up strobe. q=1, `busy` low after 3 cycles, `pm=0`.
- Run mode, q=11, `tick_hr` pulse → one up strobe, q=12, `pm` 0→1. Second tick at q=12 → two consecutive up strobes, q=1, `pm` stays 1.
- Set mode, q=1, `btn_down` edge → no down strobe, 11 consecutive up strobes, q=12, `busy` 13 cycles, `pm` unchanged. Then `btn_down` at q=12 → one down strobe, q=11, `pm` toggles.
- Set mode, `tick_hr` pulsed twice → no strobe. Drop `set_mode` → exactly one up strobe, q advances by 1.
- `btn_up` and `btn_down` rise in the same cycle → no strobes. Tick arriving during a 13-cycle FIX → served immediately after SETTLE.
- With `FORMATO_12_AUTOREPEAT_EN`, `REPEAT_DLY=8`, `REPEAT_PER=4`, `btn_up` held 20 cycles from q=3 → requests at cycles 0, 8, 12, 16; q=7. Assert `reset12` mid-sequence → outputs 0 at once, INIT restarts.

Source files
------------

// File: rtl/formato_12_ctrl.sv
// formato_12_ctrl: sequencing controller for the 12-hour counter.
// Arbitrates timekeeping ticks and set buttons into up/down strobes, keeps the
// hour inside 1..12 with corrective up bursts, and tracks the AM/PM flag.
// Optional build macro: FORMATO_12_AUTOREPEAT_EN (button auto-repeat in set mode).

module formato_12_ctrl #(
    parameter int unsigned REPEAT_DLY = 25_000_000,
    parameter int unsigned REPEAT_PER = 5_000_000
) (
    input  logic       clk12,
    input  logic       reset12,
    input  logic       set_mode,
    input  logic       tick_hr,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [3:0] q12_in,
    output logic       en12,
    output logic       up12,
    output logic       down12,
    output logic       pm,
    output logic       busy
);

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StIssue,
        StFix,
        StSettle
    } state_e;

    state_e     state_q, state_d;
    logic       en12_q, en12_d;
    logic       up12_q, up12_d;
    logic       down12_q, down12_d;
    logic       pm_q, pm_d;
    logic       pend_q, pend_d;
    logic       repair_q, repair_d;
    logic [3:0] fix_cnt_q, fix_cnt_d;
    logic       btn_up_q, btn_down_q;

    logic       up_edge, down_edge;
    logic       q_valid;
    logic       req_up, req_down;
    logic       rpt_up, rpt_down;

    // Repeat timing of zero would make the hold counter fire every cycle.
    if (REPEAT_DLY == 0 || REPEAT_PER == 0) begin : g_param_check
        $error("REPEAT_DLY and REPEAT_PER must be non-zero");
    end

    // Button level history for edge detection; sampled every cycle so that
    // edges arriving while busy are consumed rather than deferred.
    always_ff @(posedge clk12 or posedge reset12) begin
        if (reset12) begin
            btn_up_q   <= 1'b0;
            btn_down_q <= 1'b0;
        end else begin
            btn_up_q   <= btn_up;
            btn_down_q <= btn_down;
        end
    end

    assign up_edge   = btn_up & ~btn_up_q;
    assign down_edge = btn_down & ~btn_down_q;

`ifdef FORMATO_12_AUTOREPEAT_EN
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic        hold_rpt_q, hold_rpt_d;
    logic        hold_one;
    logic        hold_fire;

    // Exactly one button held in set mode keeps the hold counter running.
    assign hold_one = set_mode & (btn_up ^ btn_down);

    // Hold counter: counts cycles since press (or since last repeat); first
    // repeat after REPEAT_DLY, then every REPEAT_PER while still held.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        hold_rpt_d = hold_rpt_q;
        hold_fire  = 1'b0;
        if (!hold_one) begin
            hold_cnt_d = 32'd0;
            hold_rpt_d = 1'b0;
        end else if (hold_cnt_q == 32'd0) begin
            hold_cnt_d = 32'd1;
        end else if (hold_cnt_q == (hold_rpt_q ? REPEAT_PER : REPEAT_DLY)) begin
            hold_fire  = 1'b1;
            hold_cnt_d = 32'd1;
            hold_rpt_d = 1'b1;
        end else begin
            hold_cnt_d = hold_cnt_q + 32'd1;
        end
    end

    // Hold counter state.
    always_ff @(posedge clk12 or posedge reset12) begin
        if (reset12) begin
            hold_cnt_q <= 32'd0;
            hold_rpt_q <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            hold_rpt_q <= hold_rpt_d;
        end
    end

    // A repeat that lands outside IDLE is simply not accepted (discarded).
    assign rpt_up   = hold_fire & btn_up;
    assign rpt_down = hold_fire & btn_down;
`else
    assign rpt_up   = 1'b0;
    assign rpt_down = 1'b0;
`endif

    assign q_valid = (q12_in != 4'd0) && (q12_in <= 4'd12);

    // Simultaneous up and down edges cancel each other.
    assign req_up   = set_mode ? ((up_edge & ~down_edge) | rpt_up) : (tick_hr | pend_q);
    assign req_down = set_mode & ((down_edge & ~up_edge) | rpt_down);

    // Next state, strobe, pending-tick and AM/PM decisions.
    always_comb begin
        state_d   = state_q;
        en12_d    = 1'b0;
        up12_d    = 1'b0;
        down12_d  = 1'b0;
        pm_d      = pm_q;
        repair_d  = repair_q;
        fix_cnt_d = fix_cnt_q;
        pend_d    = pend_q;

        // Ticks that cannot be served now wait in the 1-deep pending flag.
        if (tick_hr && (set_mode || state_q != StIdle)) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            StInit: begin
                state_d   = StIssue;
                en12_d    = 1'b1;
                up12_d    = 1'b1;
                repair_d  = 1'b1;
                fix_cnt_d = 4'd0;
            end
            StIdle: begin
                if (!q_valid) begin
                    // Out-of-range hour: step up until the counter reads 1.
                    state_d   = StIssue;
                    en12_d    = 1'b1;
                    up12_d    = 1'b1;
                    repair_d  = 1'b1;
                    fix_cnt_d = 4'd0;
                    pend_d    = pend_q | tick_hr;
                end else if (req_up) begin
                    state_d   = StIssue;
                    en12_d    = 1'b1;
                    up12_d    = 1'b1;
                    fix_cnt_d = (q12_in == 4'd12) ? 4'd1 : 4'd0;
                    if (q12_in == 4'd11) begin
                        pm_d = ~pm_q;
                    end
                    if (!set_mode) begin
                        // Pending tick is served now; a tick this cycle refills it.
                        pend_d = pend_q & tick_hr;
                    end
                end else if (req_down) begin
                    en12_d = 1'b1;
                    if (q12_in == 4'd1) begin
                        // 1 -> 12 by eleven ups; the counter never steps to 0 downward.
                        state_d   = StFix;
                        up12_d    = 1'b1;
                        fix_cnt_d = 4'd10;
                    end else begin
                        state_d   = StIssue;
                        down12_d  = 1'b1;
                        fix_cnt_d = 4'd0;
                        if (q12_in == 4'd12) begin
                            pm_d = ~pm_q;
                        end
                    end
                end
            end
            StIssue: begin
                if (fix_cnt_q != 4'd0) begin
                    state_d   = StFix;
                    en12_d    = 1'b1;
                    up12_d    = 1'b1;
                    fix_cnt_d = fix_cnt_q - 4'd1;
                end else begin
                    state_d = StSettle;
                end
            end
            StFix: begin
                // fix_cnt_q holds the strobes still owed after the current one.
                if (fix_cnt_q != 4'd0) begin
                    en12_d    = 1'b1;
                    up12_d    = 1'b1;
                    fix_cnt_d = fix_cnt_q - 4'd1;
                end else begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (repair_q && q12_in != 4'd1) begin
                    state_d = StIssue;
                    en12_d  = 1'b1;
                    up12_d  = 1'b1;
                end else begin
                    state_d  = StIdle;
                    repair_d = 1'b0;
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    // State, registered strobes and flags.
    always_ff @(posedge clk12 or posedge reset12) begin
        if (reset12) begin
            state_q   <= StInit;
            en12_q    <= 1'b0;
            up12_q    <= 1'b0;
            down12_q  <= 1'b0;
            pm_q      <= 1'b0;
            pend_q    <= 1'b0;
            repair_q  <= 1'b0;
            fix_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            en12_q    <= en12_d;
            up12_q    <= up12_d;
            down12_q  <= down12_d;
            pm_q      <= pm_d;
            pend_q    <= pend_d;
            repair_q  <= repair_d;
            fix_cnt_q <= fix_cnt_d;
        end
    end

    assign en12   = en12_q;
    assign up12   = up12_q;
    assign down12 = down12_q;
    assign pm     = pm_q;
    assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_formato_12_ctrl.sv
// Directed self-checking bench for formato_12_ctrl with a behavioural hour counter.

module tb_formato_12_ctrl;

    logic       clk12 = 1'b0;
    logic       reset12;
    logic       set_mode;
    logic       tick_hr;
    logic       btn_up;
    logic       btn_down;
    logic [3:0] q12_in;
    logic       en12, up12, down12, pm, busy;

    logic [3:0] hr_q;
    logic       ld;
    logic [3:0] ld_val;

    int checks   = 0;
    int failures = 0;
    int n_up     = 0;
    int n_dn     = 0;
    int n_bad    = 0;

`ifdef FORMATO_12_AUTOREPEAT_EN
    localparam int RptUps = 4;
    localparam int RptHr  = 7;
`else
    localparam int RptUps = 1;
    localparam int RptHr  = 4;
`endif

    formato_12_ctrl #(
        .REPEAT_DLY(8),
        .REPEAT_PER(4)
    ) dut (
        .clk12   (clk12),
        .reset12 (reset12),
        .set_mode(set_mode),
        .tick_hr (tick_hr),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .q12_in  (q12_in),
        .en12    (en12),
        .up12    (up12),
        .down12  (down12),
        .pm      (pm),
        .busy    (busy)
    );

    always #5 clk12 = ~clk12;

    assign q12_in = hr_q;

    // Hour counter: up 12->0 else +1, down -1 mod 16, shares the reset net.
    always @(posedge clk12 or posedge reset12) begin
        if (reset12)                 hr_q <= 4'd0;
        else if (ld)                 hr_q <= ld_val;
        else if (en12 && up12)       hr_q <= (hr_q == 4'd12) ? 4'd0 : hr_q + 4'd1;
        else if (en12 && down12)     hr_q <= hr_q - 4'd1;
    end

    // Strobe tally; n_bad counts malformed strobe combinations.
    always @(posedge clk12) begin
        if (!reset12) begin
            if (en12 && up12 && !down12)      n_up  <= n_up + 1;
            else if (en12 && down12 && !up12) n_dn  <= n_dn + 1;
            else if (en12 || up12 || down12)  n_bad <= n_bad + 1;
        end
    end

    task automatic wait_idle(output int n, output bit to);
        n  = 0;
        to = 1'b0;
        while (busy && n < 64) begin
            n++;
            @(negedge clk12);
        end
        if (busy) to = 1'b1;
    endtask

    task automatic load_hr(input logic [3:0] v);
        ld     = 1'b1;
        ld_val = v;
        @(negedge clk12);
        ld     = 1'b0;
    endtask

    task automatic test_reset();
        int n; bit to; int u0;
        reset12 = 1'b1; set_mode = 1'b0; tick_hr = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; ld = 1'b0; ld_val = 4'd0;
        repeat (3) @(negedge clk12);
        checks++;
        if ({en12, up12, down12, pm, busy} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 00001", {en12, up12, down12, pm, busy});
        end
        u0 = n_up;
        reset12 = 1'b0;
        @(negedge clk12);
        checks++;
        if ({en12, up12, down12, busy} !== 4'b1101) begin
            failures++;
            $display("FAIL init_strobe: got %b expected 1101", {en12, up12, down12, busy});
        end
        wait_idle(n, to);
        checks++;
        if (to || n != 2) begin
            failures++;
            $display("FAIL init_busy: got %0d expected 2 after INIT", n);
        end
        checks++;
        if (hr_q !== 4'd1 || pm !== 1'b0 || n_up - u0 != 1) begin
            failures++;
            $display("FAIL init_result: got q=%0d pm=%0d ups=%0d expected q=1 pm=0 ups=1",
                     hr_q, pm, n_up - u0);
        end
    endtask

    task automatic test_tick_wrap();
        int n; bit to; int u0;
        load_hr(4'd11);
        u0 = n_up;
        tick_hr = 1'b1;
        @(negedge clk12);
        tick_hr = 1'b0;
        checks++;
        if ({en12, up12, down12, pm} !== 4'b1101) begin
            failures++;
            $display("FAIL tick11_strobe: got %b expected 1101", {en12, up12, down12, pm});
        end
        wait_idle(n, to);
        checks++;
        if (to || n != 2 || hr_q !== 4'd12 || n_up - u0 != 1) begin
            failures++;
            $display("FAIL tick11_result: got busy=%0d q=%0d ups=%0d expected 2 12 1",
                     n, hr_q, n_up - u0);
        end
        u0 = n_up;
        tick_hr = 1'b1;
        @(negedge clk12);
        tick_hr = 1'b0;
        checks++;
        if ({en12, up12} !== 2'b11) begin
            failures++;
            $display("FAIL tick12_first: got %b expected 11", {en12, up12});
        end
        @(negedge clk12);
        checks++;
        if ({en12, up12, down12} !== 3'b110) begin
            failures++;
            $display("FAIL tick12_second: got %b expected 110", {en12, up12, down12});
        end
        wait_idle(n, to);
        checks++;
        if (to || n != 2 || hr_q !== 4'd1 || pm !== 1'b1 || n_up - u0 != 2) begin
            failures++;
            $display("FAIL tick12_result: got busy=%0d q=%0d pm=%0d ups=%0d expected 2 1 1 2",
                     n, hr_q, pm, n_up - u0);
        end
    endtask

    task automatic test_set_down();
        int n; bit to; int u0; int d0;
        set_mode = 1'b1;
        @(negedge clk12);
        u0 = n_up; d0 = n_dn;
        btn_down = 1'b1;
        @(negedge clk12);
        btn_down = 1'b0;
        checks++;
        if ({en12, up12, down12} !== 3'b110) begin
            failures++;
            $display("FAIL down1_first: got %b expected 110", {en12, up12, down12});
        end
        wait_idle(n, to);
        checks++;
        if (to || n != 12) begin
            failures++;
            $display("FAIL down1_busy: got %0d expected 12 after accept", n);
        end
        checks++;
        if (hr_q !== 4'd12 || pm !== 1'b1 || n_up - u0 != 11 || n_dn != d0) begin
            failures++;
            $display("FAIL down1_result: got q=%0d pm=%0d ups=%0d downs=%0d expected 12 1 11 0",
                     hr_q, pm, n_up - u0, n_dn - d0);
        end
        d0 = n_dn;
        btn_down = 1'b1;
        @(negedge clk12);
        btn_down = 1'b0;
        checks++;
        if ({en12, up12, down12, pm} !== 4'b1010) begin
            failures++;
            $display("FAIL down12_strobe: got %b expected 1010", {en12, up12, down12, pm});
        end
        wait_idle(n, to);
        checks++;
        if (to || n != 2 || hr_q !== 4'd11 || n_dn - d0 != 1) begin
            failures++;
            $display("FAIL down12_result: got busy=%0d q=%0d downs=%0d expected 2 11 1",
                     n, hr_q, n_dn - d0);
        end
    endtask

    task automatic test_set_pending();
        int n; bit to; int u0;
        u0 = n_up;
        tick_hr = 1'b1;
        @(negedge clk12);
        tick_hr = 1'b0;
        @(negedge clk12);
        tick_hr = 1'b1;
        @(negedge clk12);
        tick_hr = 1'b0;
        repeat (4) @(negedge clk12);
        checks++;
        if (n_up != u0 || busy !== 1'b0 || hr_q !== 4'd11) begin
            failures++;
            $display("FAIL set_tick_held: got ups=%0d busy=%0d q=%0d expected 0 0 11",
                     n_up - u0, busy, hr_q);
        end
        set_mode = 1'b0;
        @(negedge clk12);
        checks++;
        if ({en12, up12, pm} !== 3'b111) begin
            failures++;
            $display("FAIL pend_served: got %b expected 111", {en12, up12, pm});
        end
        wait_idle(n, to);
        repeat (5) @(negedge clk12);
        checks++;
        if (to || hr_q !== 4'd12 || n_up - u0 != 1) begin
            failures++;
            $display("FAIL pend_once: got q=%0d ups=%0d expected 12 1", hr_q, n_up - u0);
        end
    endtask

    task automatic test_both_edges();
        int u0; int d0;
        set_mode = 1'b1;
        u0 = n_up; d0 = n_dn;
        btn_up = 1'b1; btn_down = 1'b1;
        @(negedge clk12);
        checks++;
        if ({en12, busy} !== 2'b00) begin
            failures++;
            $display("FAIL both_edges_now: got %b expected 00", {en12, busy});
        end
        repeat (3) @(negedge clk12);
        btn_up = 1'b0; btn_down = 1'b0;
        repeat (3) @(negedge clk12);
        checks++;
        if (n_up != u0 || n_dn != d0 || hr_q !== 4'd12) begin
            failures++;
            $display("FAIL both_edges: got ups=%0d downs=%0d q=%0d expected 0 0 12",
                     n_up - u0, n_dn - d0, hr_q);
        end
    endtask

    task automatic test_tick_during_fix();
        int n; bit to; int u0; logic pm0;
        set_mode = 1'b1;
        load_hr(4'd1);
        u0 = n_up; pm0 = pm;
        btn_down = 1'b1;
        @(negedge clk12);
        btn_down = 1'b0;
        set_mode = 1'b0;
        @(negedge clk12);
        @(negedge clk12);
        tick_hr = 1'b1;
        @(negedge clk12);
        tick_hr = 1'b0;
        wait_idle(n, to);
        checks++;
        if (to || n != 9 || hr_q !== 4'd12) begin
            failures++;
            $display("FAIL fix_then_idle: got busy=%0d q=%0d expected 9 12", n, hr_q);
        end
        @(negedge clk12);
        checks++;
        if ({en12, up12, busy} !== 3'b111) begin
            failures++;
            $display("FAIL tick_after_fix: got %b expected 111", {en12, up12, busy});
        end
        wait_idle(n, to);
        checks++;
        if (to || n != 3 || hr_q !== 4'd1 || n_up - u0 != 13 || pm !== pm0) begin
            failures++;
            $display("FAIL tick_after_fix_result: got busy=%0d q=%0d ups=%0d pm=%0d expected 3 1 13 %0d",
                     n, hr_q, n_up - u0, pm, pm0);
        end
    endtask

    task automatic test_repair();
        int n; bit to; int u0; logic pm0;
        pm0 = pm;
        load_hr(4'd14);
        u0 = n_up;
        @(negedge clk12);
        checks++;
        if ({en12, up12, busy} !== 3'b111) begin
            failures++;
            $display("FAIL repair_start: got %b expected 111", {en12, up12, busy});
        end
        wait_idle(n, to);
        checks++;
        if (to || n != 6 || hr_q !== 4'd1 || n_up - u0 != 3 || pm !== pm0) begin
            failures++;
            $display("FAIL repair_result: got busy=%0d q=%0d ups=%0d pm=%0d expected 6 1 3 %0d",
                     n, hr_q, n_up - u0, pm, pm0);
        end
    endtask

    task automatic test_autorepeat();
        int n; bit to; int u0; logic pm0;
        set_mode = 1'b1;
        load_hr(4'd3);
        u0 = n_up; pm0 = pm;
        btn_up = 1'b1;
        repeat (20) @(negedge clk12);
        btn_up = 1'b0;
        wait_idle(n, to);
        repeat (3) @(negedge clk12);
        checks++;
        if (to || n_up - u0 != RptUps || hr_q !== 4'(RptHr) || pm !== pm0) begin
            failures++;
            $display("FAIL hold_up: got ups=%0d q=%0d pm=%0d expected %0d %0d %0d",
                     n_up - u0, hr_q, pm, RptUps, RptHr, pm0);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n; bit to; int u0;
        set_mode = 1'b1;
        load_hr(4'd1);
        btn_down = 1'b1;
        @(negedge clk12);
        btn_down = 1'b0;
        repeat (3) @(negedge clk12);
        checks++;
        if ({en12, up12} !== 2'b11) begin
            failures++;
            $display("FAIL burst_running: got %b expected 11", {en12, up12});
        end
        reset12 = 1'b1;
        #1;
        checks++;
        if ({en12, up12, down12, pm, busy} !== 5'b00001 || hr_q !== 4'd0) begin
            failures++;
            $display("FAIL reset_mid_burst: got %b q=%0d expected 00001 q=0",
                     {en12, up12, down12, pm, busy}, hr_q);
        end
        @(negedge clk12);
        reset12  = 1'b0;
        set_mode = 1'b0;
        u0 = n_up;
        @(negedge clk12);
        wait_idle(n, to);
        checks++;
        if (to || n != 2 || hr_q !== 4'd1 || n_up - u0 != 1) begin
            failures++;
            $display("FAIL reinit: got busy=%0d q=%0d ups=%0d expected 2 1 1", n, hr_q, n_up - u0);
        end
    endtask

    initial begin
        test_reset();
        test_tick_wrap();
        test_set_down();
        test_set_pending();
        test_both_edges();
        test_tick_during_fix();
        test_repair();
        test_autorepeat();
        test_reset_mid_burst();
        checks++;
        if (n_bad != 0) begin
            failures++;
            $display("FAIL strobe_shape: got %0d malformed strobes expected 0", n_bad);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
